l2_input_arbiter_gen: RTL
=========================

// Module: l2_input_arbiter_gen
// PURPOSE
//  Parametrised N-channel input arbiter/decoder for the L2 front end (fence, rsp, fwd, cpu, ...).
//  Each decode_en cycle it picks one eligible channel and pulses its ready or replay-take.
//  It registers the one-hot grant, the grant index and the tag/set breakdown of the winner's line address.
//  Sits between the L2 input interfaces and the L2 main FSM.
// PARAMETERS
//  N_CH          4   number of input channels; index 0 = highest fixed priority
//  LINE_W        26  line-address width per channel
//  SET_BITS      8   L2 set-index bits; tag width TAG_W = LINE_W-SET_BITS
//  N_MSHR        8   MSHR count; MSHR_CNT_W = $clog2(N_MSHR+1)
//  STARVE_LIMIT  4   lost arbitrations before a channel is promoted (>=1)
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset, asynchronous, active-low
//  decode_en      in   1              arbitrate/update this cycle
//  ch_valid       in   N_CH           new input valid per channel
//  ch_replay      in   N_CH           stalled/conflict entry pending per channel (held internally by owner)
//  ch_block       in   N_CH           channel ineligible this cycle (e.g. fwd_stall, ongoing fence)
//  ch_needs_mshr  in   N_CH           channel requires mshr_cnt != 0 (free MSHR)
//  ch_needs_busy  in   N_CH           channel requires mshr_cnt != N_MSHR (outstanding MSHR)
//  ch_addr        in   N_CH*LINE_W    packed line addresses, ch i at [i*LINE_W +: LINE_W]
//  mshr_cnt       in   MSHR_CNT_W     free MSHR count
//  ch_ready       out  N_CH           comb accept pulse for new input
//  ch_replay_take out  N_CH           comb pulse: replay entry consumed
//  grant_next     out  N_CH           comb one-hot winner
//  grant          out  N_CH           registered one-hot winner
//  grant_idx      out  $clog2(N_CH)   registered winner index
//  grant_vld      out  1              registered: a channel was granted
//  line_tag       out  TAG_W          registered winner tag
//  line_set       out  SET_BITS       registered winner set
//  starve_flag    out  N_CH           registered: channel at STARVE_LIMIT
// BEHAVIOUR
//  - elig[i] = (ch_valid[i]|ch_replay[i]) & !ch_block[i] & (!ch_needs_mshr[i] | mshr_cnt!=0)
//              & (!ch_needs_busy[i] | mshr_cnt!=N_MSHR).
//  - decode_en=0: grant_next, ch_ready and ch_replay_take all 0; registers and counters hold.
//  - decode_en=1: S = elig & starve_flag; grant_next = lowest set bit of S if S!=0, else lowest set bit of elig.
//    No eligible channel: grant_next = 0.
//  - ch_replay_take[i] = grant_next[i] & ch_replay[i].
//  - ch_ready[i] = grant_next[i] & !ch_replay[i]. A pending replay beats a new valid on the same channel.
//  - Latency: ready/replay_take combinational in the decode cycle; grant/grant_idx/grant_vld/line_tag/line_set
//    valid the next cycle and held until the next decode_en.
//  - Register update on decode_en: grant<=grant_next; grant_vld<=|grant_next; grant_idx<=index of winner (0 if none).
//    line_tag<=addr[LINE_W-1:SET_BITS] of winner, 0 if none; line_set<=addr[SET_BITS-1:0] of winner, 0 if none.
//  - mshr_cnt outside 0..N_MSHR is illegal; no checking.
//  - Reset (async, any cycle incl. mid-operation): every registered output, all wait counters and
//    starve_flag go to 0; comb outputs follow inputs with zeroed state.
// CONFIGURATION
//  - L2_ARB_STARVE_GUARD_EN defined: per-channel wait_cnt, width $clog2(STARVE_LIMIT+1); ch0 counter tied to 0.
//    Updated on decode_en only, per channel:
//      !(ch_valid|ch_replay) -> 0;  grant_next[i] -> 0;  elig & not granted -> saturating +1 at STARVE_LIMIT;
//      blocked -> hold.
//    starve_flag[i] = (wait_cnt[i] == STARVE_LIMIT).
//  - Not defined: no counters; starve_flag tied to 0; pure fixed priority.
// TESTING
//  1. N_CH=4, decode_en=1, ch_valid=4'b1010 -> grant_next=0010, ch_ready=0010; next cycle grant_idx=1, grant_vld=1,
//     line_set=ch_addr[1] low SET_BITS.
//  2. mshr_cnt=0, ch_needs_mshr=0010, ch_valid=1010 -> grant_next=1000; mshr_cnt=N_MSHR, ch_needs_busy=1000 -> grant 0.
//  3. ch_valid[2]=1, ch_replay[2]=1, others idle -> ch_replay_take=0100, ch_ready=0000.
//  4. Macro on, STARVE_LIMIT=4, ch0 and ch3 valid every decode -> ch0 wins 4 decodes, starve_flag[3]=1, 5th grants ch3,
//     then counter 0. Macro off -> ch3 never granted.
//  5. decode_en=0 with ch_valid=1111 -> ch_ready=0; grant/line_tag unchanged from the previous decode.
//  6. rst low mid-stream with grant_vld=1 -> all registered outputs 0 without a clock edge; first decode after release
//     is plain priority.

Source files
------------

// File: rtl/l2_input_arbiter_gen_if.sv
// l2_input_arbiter_gen_if
//   Bundles the L2 front-end channel request signals and the arbiter result
//   signals for l2_input_arbiter_gen.
//   master: the L2 input side. It drives decode_en, the ch_* request vectors
//           and mshr_cnt, and receives the grant results.
//   slave : the arbiter. It receives the requests and drives ch_ready,
//           ch_replay_take, grant_next, grant, grant_idx, grant_vld,
//           line_tag, line_set and starve_flag.
//   The parameters must match those of the arbiter instance.
interface l2_input_arbiter_gen_if #(
  parameter int N_CH     = 4,
  parameter int LINE_W   = 26,
  parameter int SET_BITS = 8,
  parameter int N_MSHR   = 8
);
  localparam int MSHR_CNT_W = $clog2(N_MSHR + 1);
  localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TAG_W      = LINE_W - SET_BITS;

  logic                     decode_en;
  logic [N_CH-1:0]          ch_valid;
  logic [N_CH-1:0]          ch_replay;
  logic [N_CH-1:0]          ch_block;
  logic [N_CH-1:0]          ch_needs_mshr;
  logic [N_CH-1:0]          ch_needs_busy;
  logic [N_CH*LINE_W-1:0]   ch_addr;
  logic [MSHR_CNT_W-1:0]    mshr_cnt;
  logic [N_CH-1:0]          ch_ready;
  logic [N_CH-1:0]          ch_replay_take;
  logic [N_CH-1:0]          grant_next;
  logic [N_CH-1:0]          grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_vld;
  logic [TAG_W-1:0]         line_tag;
  logic [SET_BITS-1:0]      line_set;
  logic [N_CH-1:0]          starve_flag;

  modport master (
    output decode_en, ch_valid, ch_replay, ch_block, ch_needs_mshr,
           ch_needs_busy, ch_addr, mshr_cnt,
    input  ch_ready, ch_replay_take, grant_next, grant, grant_idx,
           grant_vld, line_tag, line_set, starve_flag
  );

  modport slave (
    input  decode_en, ch_valid, ch_replay, ch_block, ch_needs_mshr,
           ch_needs_busy, ch_addr, mshr_cnt,
    output ch_ready, ch_replay_take, grant_next, grant, grant_idx,
           grant_vld, line_tag, line_set, starve_flag
  );
endinterface

// File: rtl/l2_input_arbiter_gen.sv
// l2_input_arbiter_gen
//   N-channel input arbiter and decoder for the L2 front end. On each
//   decode_en cycle it selects one eligible channel. Channel 0 has the highest
//   fixed priority, and channels flagged as starving take precedence. It then
//   pulses ch_ready for a new input, or ch_replay_take when the winner has a
//   pending replay. The one-hot grant, the grant index and the tag/set split of
//   the winner's line address are registered for the L2 main FSM.
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   bus (slave)     decode_en, ch_valid/replay/block/needs_mshr/needs_busy,
//                   ch_addr, mshr_cnt in; ch_ready, ch_replay_take,
//                   grant_next (comb); grant, grant_idx, grant_vld,
//                   line_tag, line_set, starve_flag (registered) out
// Configuration
//   L2_ARB_STARVE_GUARD_EN  When defined, each channel has a wait counter that
//                           promotes the channel after STARVE_LIMIT lost
//                           arbitrations. When undefined, arbitration is pure
//                           fixed priority and starve_flag stays 0.
module l2_input_arbiter_gen #(
  parameter int N_CH         = 4,
  parameter int LINE_W       = 26,
  parameter int SET_BITS     = 8,
  parameter int N_MSHR       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  l2_input_arbiter_gen_if.slave bus
);
  localparam int MSHR_CNT_W = $clog2(N_MSHR + 1);
  localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TAG_W      = LINE_W - SET_BITS;
  localparam logic [MSHR_CNT_W-1:0] MSHR_FULL = MSHR_CNT_W'(N_MSHR);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("l2_input_arbiter_gen: STARVE_LIMIT must be >= 1");
  end

  logic [N_CH-1:0]     elig;
  logic [N_CH-1:0]     starve;
  logic [N_CH-1:0]     cand;
  logic [N_CH-1:0]     gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [LINE_W-1:0]   win_addr;
  logic                found;
  logic                mshr_free;
  logic                mshr_busy;

  logic [N_CH-1:0]     grant_q;
  logic [IDX_W-1:0]    grant_idx_q;
  logic                grant_vld_q;
  logic [TAG_W-1:0]    line_tag_q;
  logic [SET_BITS-1:0] line_set_q;

  assign mshr_free = (bus.mshr_cnt != '0);
  assign mshr_busy = (bus.mshr_cnt != MSHR_FULL);

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      elig[i] = (bus.ch_valid[i] | bus.ch_replay[i]) & ~bus.ch_block[i]
              & (~bus.ch_needs_mshr[i] | mshr_free)
              & (~bus.ch_needs_busy[i] | mshr_busy);
    end
  end

  // Starving channels form their own priority tier. Fixed priority applies
  // within that tier, and the plain eligible set is used only when no
  // channel is starving.
  always_comb begin
    cand     = '0;
    gnt      = '0;
    gnt_idx  = '0;
    win_addr = '0;
    found    = 1'b0;
    if (bus.decode_en) begin
      cand = (|(elig & starve)) ? (elig & starve) : elig;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!found && cand[i]) begin
          found    = 1'b1;
          gnt[i]   = 1'b1;
          gnt_idx  = IDX_W'(i);
          win_addr = bus.ch_addr[i*LINE_W +: LINE_W];
        end
      end
    end
  end

  assign bus.grant_next     = gnt;
  assign bus.ch_replay_take = gnt & bus.ch_replay;
  assign bus.ch_ready       = gnt & ~bus.ch_replay;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q     <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
      line_tag_q  <= '0;
      line_set_q  <= '0;
    end else if (bus.decode_en) begin
      grant_q     <= gnt;
      grant_idx_q <= gnt_idx;
      grant_vld_q <= found;
      line_tag_q  <= win_addr[LINE_W-1:SET_BITS];
      line_set_q  <= win_addr[SET_BITS-1:0];
    end
  end

`ifdef L2_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt [N_CH];

  // Channel 0 always wins on its own, so its counter is held at 0. A pending
  // but blocked channel keeps its count and does not lose its place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_CH; i++) wait_cnt[i] <= '0;
    end else if (bus.decode_en) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (i == 0 || !(bus.ch_valid[i] | bus.ch_replay[i]) || gnt[i])
          wait_cnt[i] <= '0;
        else if (elig[i] && wait_cnt[i] != LIMIT)
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int unsigned i = 0; i < N_CH; i++) starve[i] = (wait_cnt[i] == LIMIT);
  end
`else
  assign starve = '0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_vld   = grant_vld_q;
  assign bus.line_tag    = line_tag_q;
  assign bus.line_set    = line_set_q;
  assign bus.starve_flag = starve;
endmodule
